// File: rtl/btn_pkg.sv
// ============================================================================
//  Module      : btn_pkg
//  Description : Shared constants for the pushbutton conditioning slice:
//                debounce FSM state encodings and stability-window defaults.
//  Contents    : c_ST_W, c_REL_IDLE .. c_PRS_WAIT, c_STABLE_CYCLES_BOARD,
//                c_STABLE_CYCLES_SIM
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package btn_pkg;

    // Debounce FSM state encoding
    localparam int         c_ST_W     = 2;
    localparam logic [1:0] c_REL_IDLE = 2'd0;
    localparam logic [1:0] c_REL_WAIT = 2'd1;
    localparam logic [1:0] c_PRS_IDLE = 2'd2;
    localparam logic [1:0] c_PRS_WAIT = 2'd3;

    // 20 ms stability window on the 50 MHz board clock
    localparam int c_STABLE_CYCLES_BOARD = 1000000;
    // Short window so simulations stay fast
    localparam int c_STABLE_CYCLES_SIM   = 4;

endpackage : btn_pkg

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchroniser for asynchronous inputs, with a
//                synchronous reset that loads a parameterised idle value so
//                an idle pin does not look like activity after reset.
//  Ports       : clk  - system clock
//                rst  - synchronous active-high reset
//                i_d  - asynchronous input(s)
//                o_q  - synchronised output(s)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter int               WIDTH    = 1,
    parameter logic [WIDTH-1:0] IDLE_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;

    // The raw input lands directly in r_sync1; nothing combinational sits
    // in front of the first flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= IDLE_VAL;
            r_sync2 <= IDLE_VAL;
        end else begin
            r_sync1 <= i_d;
            r_sync2 <= r_sync1;
        end
    end

    assign o_q = r_sync2;

endmodule : sync_2ff

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
//  Module      : btn_debounce
//  Description : Pushbutton conditioner. Synchronises the raw pin, rejects
//                bounce shorter than STABLE_CYCLES and presents a clean
//                active-high level plus one-cycle press/release strobes.
//  Ports       : clk       - system clock
//                reset     - synchronous active-high reset
//                btn_raw   - asynchronous pushbutton pin
//                btn_level - debounced level, 1 = pressed
//                btn_rise  - one-cycle strobe on accepted press
//                btn_fall  - one-cycle strobe on accepted release
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce
    import btn_pkg::*;
#(
    parameter int STABLE_CYCLES = c_STABLE_CYCLES_BOARD,
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall
);

    // Pin value while the button is released
    localparam logic             c_PIN_IDLE = ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic              w_sync;
    logic              w_pressed;
    logic [c_ST_W-1:0] r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_level;
    logic              r_rise;
    logic              r_fall;

    sync_2ff #(
        .WIDTH    (1),
        .IDLE_VAL (c_PIN_IDLE)
    ) u_sync (
        .clk (clk),
        .rst (reset),
        .i_d (btn_raw),
        .o_q (w_sync)
    );

    // Normalised: 1 means the button is physically pressed
    assign w_pressed = ACTIVE_LOW ? ~w_sync : w_sync;

    // The counter holds how many consecutive cycles the candidate value has
    // been seen, so entering a WAIT state loads 1 and acceptance happens when
    // the STABLE_CYCLES-th consecutive sample arrives.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_REL_IDLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                c_REL_IDLE: begin
                    r_cnt <= '0;
                    if (w_pressed) begin
                        r_state <= c_REL_WAIT;
                        r_cnt   <= c_CNT_ONE;
                    end
                end
                c_REL_WAIT: begin
                    if (!w_pressed) begin
                        r_state <= c_REL_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_state <= c_PRS_IDLE;
                        r_cnt   <= '0;
                        r_level <= 1'b1;
                        r_rise  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_PRS_IDLE: begin
                    r_cnt <= '0;
                    if (!w_pressed) begin
                        r_state <= c_PRS_WAIT;
                        r_cnt   <= c_CNT_ONE;
                    end
                end
                c_PRS_WAIT: begin
                    if (w_pressed) begin
                        r_state <= c_PRS_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_state <= c_REL_IDLE;
                        r_cnt   <= '0;
                        r_level <= 1'b0;
                        r_fall  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= c_REL_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign btn_level = r_level;
    assign btn_rise  = r_rise;
    assign btn_fall  = r_fall;

endmodule : btn_debounce

`default_nettype wire

// File: tb/tb_btn_debounce.sv
// ============================================================================
//  Module      : tb_btn_debounce
//  Description : Self-checking bench for btn_debounce (STABLE_CYCLES = 4,
//                ACTIVE_LOW = 1). A run-length reference model predicts the
//                outputs every cycle; directed scenarios pin exact latencies.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btn_debounce;
    import btn_pkg::*;

    localparam int c_STABLE = c_STABLE_CYCLES_SIM;

    logic clk;
    logic reset;
    logic btn_raw;
    logic btn_level;
    logic btn_rise;
    logic btn_fall;

    int checks = 0;
    int errors = 0;

    btn_debounce #(
        .STABLE_CYCLES (c_STABLE),
        .ACTIVE_LOW    (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Pressed samples pass through a two-stage delay; the level flips once
    // the delayed value has disagreed with it for c_STABLE consecutive edges.
    logic m_init  = 1'b0;
    logic m_p1, m_p2;
    logic m_level, m_rise, m_fall;
    int   m_run;

    always @(posedge clk) begin
        if (reset) begin
            m_init  = 1'b1;
            m_p1    = 1'b0;
            m_p2    = 1'b0;
            m_level = 1'b0;
            m_rise  = 1'b0;
            m_fall  = 1'b0;
            m_run   = 0;
        end else if (m_init) begin
            logic s;
            s      = m_p2;
            m_p2   = m_p1;
            m_p1   = ~btn_raw;
            m_rise = 1'b0;
            m_fall = 1'b0;
            m_run  = (s != m_level) ? m_run + 1 : 0;
            if (m_run == c_STABLE) begin
                m_level = ~m_level;
                m_rise  = m_level;
                m_fall  = ~m_level;
                m_run   = 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int n_rise = 0;
    int n_fall = 0;

    always @(negedge clk) begin
        if (m_init) begin
            check("level", int'(btn_level), int'(m_level));
            check("rise",  int'(btn_rise),  int'(m_rise));
            check("fall",  int'(btn_fall),  int'(m_fall));
            check("rise_fall_exclusive", int'(btn_rise & btn_fall), 0);
            if (btn_rise === 1'b1) n_rise++;
            if (btn_fall === 1'b1) n_fall++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Number of rising edges (first edge after the call = 1) until
    // btn_level reaches target; -1 if it never does within the budget.
    task automatic wait_level(input logic target, output int edges);
        edges = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (btn_level === target) begin
                edges = i;
                return;
            end
        end
    endtask

    initial begin
        int e, nr, nf;
        reset   = 1'b1;
        btn_raw = 1'b1;

        // Reset with button released, then idle
        step(3);
        reset = 1'b0;
        step(10);
        check("idle_level", int'(btn_level), 0);
        check("idle_strobes", n_rise + n_fall, 0);

        // Press: first sampling edge is edge 1, level at edge 1+c_STABLE+1
        nf = n_fall;
        btn_raw = 1'b0;
        wait_level(1'b1, e);
        check("press_latency", e, 6);
        check("press_rise", int'(btn_rise), 1);
        @(posedge clk); #1;
        check("press_rise_one_cycle", int'(btn_rise), 0);
        step(4);
        check("press_no_fall", n_fall - nf, 0);

        // Release
        nr = n_rise;
        btn_raw = 1'b1;
        wait_level(1'b0, e);
        check("release_latency", e, 6);
        check("release_fall", int'(btn_fall), 1);
        @(posedge clk); #1;
        check("release_fall_one_cycle", int'(btn_fall), 0);
        step(4);
        check("release_no_rise", n_rise - nr, 0);

        // Bounce shorter than the window
        nr = n_rise; nf = n_fall;
        btn_raw = 1'b0; step(3);
        btn_raw = 1'b1; step(1);
        btn_raw = 1'b0; step(2);
        btn_raw = 1'b1; step(5);
        step(4);
        check("bounce_level", int'(btn_level), 0);
        check("bounce_strobes", (n_rise - nr) + (n_fall - nf), 0);

        // Bounce then settle low
        nr = n_rise;
        for (int i = 0; i < 6; i++) begin
            btn_raw = i[0];
            step(1);
        end
        btn_raw = 1'b0;
        wait_level(1'b1, e);
        check("settle_latency", e, 6);
        step(6);
        check("settle_one_rise", n_rise - nr, 1);
        btn_raw = 1'b1;
        step(10);
        check("settle_release_level", int'(btn_level), 0);

        // Reset while counting, button held through reset
        btn_raw = 1'b0;
        step(4);
        reset = 1'b1;
        step(2);
        check("rst_mid_level", int'(btn_level), 0);
        reset = 1'b0;
        nf = n_fall;
        wait_level(1'b1, e);
        check("rst_mid_latency", e, 6);
        check("rst_mid_rise", int'(btn_rise), 1);
        step(3);
        check("rst_mid_no_fall", n_fall - nf, 0);
        btn_raw = 1'b1;
        step(10);

        // Randomised hold lengths with occasional resets
        for (int k = 0; k < 400; k++) begin
            int len;
            btn_raw = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 12))
                                              : int'($urandom_range(1, 5));
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b1;
                step(int'($urandom_range(1, 3)));
                reset = 1'b0;
            end
            step(len);
        end
        btn_raw = 1'b1;
        step(10);
        check("random_final_level", int'(btn_level), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_btn_debounce

`default_nettype wire
